serial_adder: RTL and testbench

//  Bit-serial, LSB-first adder of two WIDTH-bit unsigned/two's-complement operands; the addition counterpart of the sub unit.

---
 rtl/serial_arith_pkg.sv | 16 +
 rtl/full_add.sv | 16 +
 rtl/serial_adder.sv | 123 ++++++++++++
 tb/tb_serial_adder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and limits for the bit-serial arithmetic units.
package serial_arith_pkg;

    localparam int unsigned SA_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        SA_IDLE,
        SA_RUN,
        SA_DONE
    } sa_state_t;

    function automatic logic sa_width_ok(input int unsigned w);
        return (w >= 1) && (w <= SA_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/full_add.sv
// Combinational 1-bit full-adder cell used by the serial adder datapath.
module full_add (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;

    assign w_p  = a ^ b;
    assign s    = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell, a carry flop, WIDTH-cycle latency.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    if (!sa_width_ok(WIDTH)) begin : g_bad_width
        $error("serial_adder: WIDTH out of range");
    end

    sa_state_t        r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    logic             w_s;
    logic             w_co;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    full_add u_full_add (
        .a    (r_op_a[0]),
        .b    (r_op_b[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_co)
    );

    assign w_last = (r_cnt == LAST_BIT);
    // New result bit enters at the MSB; written as a shift so WIDTH=1 stays legal.
    assign w_res_next = (r_res >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SA_IDLE;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                SA_IDLE, SA_DONE: begin
                    if (start) begin
                        r_op_a  <= a;
                        r_op_b  <= b;
                        r_res   <= '0;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SA_RUN;
                    end else begin
                        r_state <= SA_IDLE;
                    end
                end
                SA_RUN: begin
                    r_op_a  <= r_op_a >> 1;
                    r_op_b  <= r_op_b >> 1;
                    r_res   <= w_res_next;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= SA_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_sum   <= w_res_next;
                        r_cout  <= w_co;
`ifdef SERIAL_ADDER_OVF_EN
                        // r_carry is the carry into the MSB on this edge.
                        r_ovf   <= r_carry ^ w_co;
`endif
                    end
                end
                default: r_state <= SA_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH 1, 8 and 32 driven by shared stimulus.
module tb_serial_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } lit_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;

    int n_tests;
    int n_fail;
    int n_timeouts;
    int to_seen;

    lit_t lq0[$];
    lit_t lq1[$];
    lit_t lq2[$];
    lit_t e_cur;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 3; g++) begin : gen_w
        localparam int W = (g == 0) ? 1 : (g == 1) ? 8 : 32;
        localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;

        logic         d_busy;
        logic         d_done;
        logic         d_cout;
        logic         d_ovf;
        logic [W-1:0] d_sum;

        bit           m_active;
        int           m_left;
        logic [31:0]  m_a;
        logic [31:0]  m_b;
        logic [63:0]  m_full;
        logic         m_busy;
        logic         m_done;
        logic [31:0]  m_sum;
        logic         m_cout;
        logic         m_ovf;

        serial_adder #(
            .WIDTH (W)
        ) dut (
            .clk   (clk),
            .rst   (rst),
            .start (start),
            .a     (a[W-1:0]),
            .b     (b[W-1:0]),
            .busy  (d_busy),
            .done  (d_done),
            .sum   (d_sum),
            .cout  (d_cout)
`ifdef SERIAL_ADDER_OVF_EN
            ,
            .ovf   (d_ovf)
`endif
        );
`ifndef SERIAL_ADDER_OVF_EN
        assign d_ovf = 1'b0;
`endif

        // Reference: an accepted op completes W edges later with the arithmetic sum.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                m_active = 0;
                m_left   = 0;
                m_busy   = 1'b0;
                m_done   = 1'b0;
                m_sum    = '0;
                m_cout   = 1'b0;
                m_ovf    = 1'b0;
            end else begin
                m_done = 1'b0;
                if (m_active) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_full   = {32'd0, m_a} + {32'd0, m_b};
                        m_sum    = 32'(m_full & MASK);
                        m_cout   = m_full[W];
                        m_ovf    = (m_a[W-1] == m_b[W-1]) && (m_sum[W-1] != m_a[W-1]);
                        m_active = 0;
                        m_done   = 1'b1;
                    end
                end else if (start) begin
                    m_active = 1;
                    m_left   = W;
                    m_a      = a & 32'(MASK);
                    m_b      = b & 32'(MASK);
                end
                m_busy = m_active;
            end
        end
    end

    task automatic chk(input string nm, input int w, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s w=%0d t=%0t: got %h expected %h", nm, w, $time, act, exp);
        end
    endtask

    task automatic rst_blk(input int w, input logic bsy, input logic dn, input logic [31:0] s,
                           input logic co, input logic ov);
        chk("rst_busy", w, 32'(bsy), 32'd0);
        chk("rst_done", w, 32'(dn), 32'd0);
        chk("rst_sum", w, s, 32'd0);
        chk("rst_cout", w, 32'(co), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", w, 32'(ov), 32'd0);
`else
        if (ov !== 1'b0) chk("rst_ovf", w, 32'(ov), 32'd0);
`endif
    endtask

    task automatic cmp_blk(input int w, input logic bsy, input logic dn, input logic [31:0] s,
                           input logic co, input logic ov, input logic mbsy, input logic mdn,
                           input logic [31:0] ms, input logic mco, input logic mov);
        chk("busy", w, 32'(bsy), 32'(mbsy));
        chk("done", w, 32'(dn), 32'(mdn));
        chk("sum", w, s, ms);
        chk("cout", w, 32'(co), 32'(mco));
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", w, 32'(ov), 32'(mov));
`else
        if (ov !== 1'b0) chk("ovf", w, 32'(ov), 32'(mov));
`endif
    endtask

    task automatic lit_blk(input int w, input logic [31:0] s, input logic co, input logic ov,
                           input logic [31:0] ms, input lit_t e);
        chk("lit_sum", w, s, e.sum);
        chk("lit_cout", w, 32'(co), 32'(e.cout));
        chk("lit_model_sum", w, ms, e.sum);
`ifdef SERIAL_ADDER_OVF_EN
        chk("lit_ovf", w, 32'(ov), 32'(e.ovf));
`else
        if (ov !== 1'b0) chk("lit_ovf", w, 32'(ov), 32'(e.ovf));
`endif
    endtask

    // Single checker process: owns all pass/fail counting.
    always @(posedge clk or posedge rst) begin
        #1;
        if (rst) begin
            rst_blk(1, gen_w[0].d_busy, gen_w[0].d_done, 32'(gen_w[0].d_sum),
                    gen_w[0].d_cout, gen_w[0].d_ovf);
            rst_blk(8, gen_w[1].d_busy, gen_w[1].d_done, 32'(gen_w[1].d_sum),
                    gen_w[1].d_cout, gen_w[1].d_ovf);
            rst_blk(32, gen_w[2].d_busy, gen_w[2].d_done, 32'(gen_w[2].d_sum),
                    gen_w[2].d_cout, gen_w[2].d_ovf);
        end else begin
            cmp_blk(1, gen_w[0].d_busy, gen_w[0].d_done, 32'(gen_w[0].d_sum), gen_w[0].d_cout,
                    gen_w[0].d_ovf, gen_w[0].m_busy, gen_w[0].m_done, gen_w[0].m_sum,
                    gen_w[0].m_cout, gen_w[0].m_ovf);
            cmp_blk(8, gen_w[1].d_busy, gen_w[1].d_done, 32'(gen_w[1].d_sum), gen_w[1].d_cout,
                    gen_w[1].d_ovf, gen_w[1].m_busy, gen_w[1].m_done, gen_w[1].m_sum,
                    gen_w[1].m_cout, gen_w[1].m_ovf);
            cmp_blk(32, gen_w[2].d_busy, gen_w[2].d_done, 32'(gen_w[2].d_sum), gen_w[2].d_cout,
                    gen_w[2].d_ovf, gen_w[2].m_busy, gen_w[2].m_done, gen_w[2].m_sum,
                    gen_w[2].m_cout, gen_w[2].m_ovf);
            if (gen_w[0].d_done && lq0.size() > 0) begin
                e_cur = lq0.pop_front();
                lit_blk(1, 32'(gen_w[0].d_sum), gen_w[0].d_cout, gen_w[0].d_ovf,
                        gen_w[0].m_sum, e_cur);
            end
            if (gen_w[1].d_done && lq1.size() > 0) begin
                e_cur = lq1.pop_front();
                lit_blk(8, 32'(gen_w[1].d_sum), gen_w[1].d_cout, gen_w[1].d_ovf,
                        gen_w[1].m_sum, e_cur);
            end
            if (gen_w[2].d_done && lq2.size() > 0) begin
                e_cur = lq2.pop_front();
                lit_blk(32, 32'(gen_w[2].d_sum), gen_w[2].d_cout, gen_w[2].d_ovf,
                        gen_w[2].m_sum, e_cur);
            end
        end
        if (n_timeouts != to_seen) begin
            chk("wait_bound", 0, 32'(n_timeouts), 32'(to_seen));
            to_seen = n_timeouts;
        end
    end

    task automatic issue(input logic [31:0] va, input logic [31:0] vb);
        start = 1'b1;
        a     = va;
        b     = vb;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done8();
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (gen_w[1].d_done) seen = 1;
            else @(negedge clk);
        end
        if (!seen) n_timeouts++;
    endtask

    task automatic wait_idle();
        bit seen;
        seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (!gen_w[0].d_busy && !gen_w[1].d_busy && !gen_w[2].d_busy) seen = 1;
        end
        if (!seen) n_timeouts++;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        n_timeouts = 0;
        to_seen    = 0;
        rst        = 1'b1;
        start      = 1'b0;
        a          = '0;
        b          = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Async reset mid-run: outputs clear immediately, no done afterwards.
        issue(32'h1234_5678, 32'h0F0F_0F0F);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_idle();

        lq0.push_back('{32'h1, 1'b0, 1'b0});
        lq1.push_back('{32'h8D, 1'b0, 1'b1});
        lq2.push_back('{32'h8D, 1'b0, 1'b0});
        issue(32'h5A, 32'h33);
        wait_idle();

        lq0.push_back('{32'h0, 1'b1, 1'b1});
        lq1.push_back('{32'h00, 1'b1, 1'b0});
        lq2.push_back('{32'h0, 1'b1, 1'b0});
        issue(32'hFFFF_FFFF, 32'h1);
        wait_idle();

        lq0.push_back('{32'h0, 1'b1, 1'b1});
        lq1.push_back('{32'h80, 1'b0, 1'b1});
        lq2.push_back('{32'h80, 1'b0, 1'b0});
        issue(32'h7F, 32'h1);
        wait_idle();

        // start pulses during RUN must be ignored.
        lq1.push_back('{32'h32, 1'b0, 1'b0});
        lq2.push_back('{32'h32, 1'b0, 1'b0});
        issue(32'h10, 32'h22);
        repeat (2) @(negedge clk);
        issue(32'hAB, 32'hCD);
        @(negedge clk);
        issue(32'h5, 32'h6);
        wait_idle();

        // Back-to-back: start held in the DONE cycle.
        lq1.push_back('{32'hFF, 1'b0, 1'b0});
        lq2.push_back('{32'hFF, 1'b0, 1'b0});
        issue(32'h0F, 32'hF0);
        wait_done8();
        lq1.push_back('{32'h03, 1'b0, 1'b0});
        issue(32'h1, 32'h2);
        wait_done8();
        wait_idle();

        // Reset while bit 4 is in flight, then a clean op.
        issue(32'h55, 32'hAA);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lq0.push_back('{32'h0, 1'b0, 1'b0});
        lq1.push_back('{32'h30, 1'b0, 1'b0});
        lq2.push_back('{32'h30, 1'b0, 1'b0});
        issue(32'h10, 32'h20);
        wait_idle();

        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 3) == 0);
            a     = $urandom;
            b     = $urandom;
            rst   = ($urandom_range(0, 249) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        rst   = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
